// File: rtl/img_tx_pkg.sv
// img_tx_pkg: states and header constants shared by the image UART transmit path.
package img_tx_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, LOAD, WAIT_CTS, SEND, DONE} img_tx_state_e;
  localparam logic [7:0] IMG_TX_SYNC0 = 8'hA5;
  localparam logic [7:0] IMG_TX_SYNC1 = 8'h5A;
  localparam int IMG_TX_HDR_LEN = 4;
endpackage

// File: rtl/img_to_uart_raster_counter.sv
// raster_counter: row/column walker over a HEIGHT x WIDTH frame; wraps to (0,0) after the last pixel.
module raster_counter #(
  parameter int HEIGHT = 120,
  parameter int WIDTH = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       clear,
  output logic [7:0] row_idx,
  output logic [7:0] col_idx,
  output logic       last
);
  logic col_end;
  assign col_end = col_idx == 8'(WIDTH - 1);
  assign last = col_end && row_idx == 8'(HEIGHT - 1);
  always_ff @(posedge clk) begin
    if (rst || clear || (advance && last)) begin
      row_idx <= 8'd0;
      col_idx <= 8'd0;
    end else if (advance) begin
      col_idx <= col_end ? 8'd0 : col_idx + 8'd1;
      row_idx <= col_end ? row_idx + 8'd1 : row_idx;
    end
  end
endmodule

// File: rtl/img_to_uart.sv
// img_to_uart: streams a stored frame over UART in raster order with CTS gating; define IMG_TX_HEADER_EN for a 4-byte header.
module img_to_uart
  import img_tx_pkg::*;
#(
  parameter int IMG_HEIGHT = 120,
  parameter int IMG_WIDTH = 160
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       img_send_start,
  input  logic       laptop_can_receive,
  input  logic [7:0] pix_data,
  input  logic       uart_data_sent,
  output logic [7:0] row_idx,
  output logic [7:0] col_idx,
  output logic       send_uart_data,
  output logic [7:0] uart_data_tx,
  output logic       img_send_busy,
  output logic       img_send_done
);
  img_tx_state_e state_q;
  logic last, advance, accept, sent;
  assign accept = state_q == IDLE && img_send_start;
  assign sent = state_q == SEND && uart_data_sent;
`ifdef IMG_TX_HEADER_EN
  logic [1:0] hdr_cnt_q;
  logic hdr_q;
  logic [7:0] hdr_byte;
  assign hdr_byte = hdr_cnt_q == 2'd0 ? IMG_TX_SYNC0 :
                    hdr_cnt_q == 2'd1 ? IMG_TX_SYNC1 :
                    hdr_cnt_q == 2'd2 ? 8'(IMG_HEIGHT) : 8'(IMG_WIDTH);
  assign advance = sent && !hdr_q;
`else
  assign advance = sent;
`endif
  raster_counter #(.HEIGHT(IMG_HEIGHT), .WIDTH(IMG_WIDTH)) u_raster (
    .clk(clock), .rst(reset), .advance(advance), .clear(accept),
    .row_idx(row_idx), .col_idx(col_idx), .last(last)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      send_uart_data <= 1'b0;
      uart_data_tx <= 8'd0;
      img_send_busy <= 1'b0;
      img_send_done <= 1'b0;
`ifdef IMG_TX_HEADER_EN
      hdr_cnt_q <= 2'd0;
      hdr_q <= 1'b0;
`endif
    end else begin
      img_send_done <= 1'b0;
      case (state_q)
        IDLE: if (img_send_start) begin
          img_send_busy <= 1'b1;
`ifdef IMG_TX_HEADER_EN
          state_q <= HDR;
          hdr_q <= 1'b1;
          hdr_cnt_q <= 2'd0;
`else
          state_q <= FETCH;
`endif
        end
`ifdef IMG_TX_HEADER_EN
        HDR: begin
          uart_data_tx <= hdr_byte;
          send_uart_data <= laptop_can_receive;
          state_q <= laptop_can_receive ? SEND : WAIT_CTS;
        end
`endif
        FETCH: state_q <= LOAD;
        LOAD: begin
          uart_data_tx <= pix_data;
          send_uart_data <= laptop_can_receive;
          state_q <= laptop_can_receive ? SEND : WAIT_CTS;
        end
        WAIT_CTS: if (laptop_can_receive) begin
          send_uart_data <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (uart_data_sent) begin
          send_uart_data <= 1'b0;
`ifdef IMG_TX_HEADER_EN
          if (hdr_q) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            hdr_q <= hdr_cnt_q != 2'(IMG_TX_HDR_LEN - 1);
            state_q <= hdr_cnt_q == 2'(IMG_TX_HDR_LEN - 1) ? FETCH : HDR;
          end else
`endif
          begin
            state_q <= last ? DONE : FETCH;
            img_send_done <= last;
          end
        end
        DONE: begin
          img_send_busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_to_uart.sv
// tb_img_to_uart: scoreboard bench for img_to_uart on a 2x3 and a 1x1 frame; follows IMG_TX_HEADER_EN.
`timescale 1ns/1ps
module tb_img_to_uart;
  localparam int H = 2, W = 3;
`ifdef IMG_TX_HEADER_EN
  localparam int LAT = 2, NHDR = 4;
`else
  localparam int LAT = 3, NHDR = 0;
`endif
  logic clk = 0, rst = 1;
  logic start = 0, cts = 1, sent = 0;
  logic [7:0] pix = 0, row, col, tx;
  logic send, busy, done;
  logic start1 = 0, sent1 = 0;
  logic [7:0] pix1 = 8'h3C, row1, col1, tx1;
  logic send1, busy1, done1;
  int total = 0, bad = 0;
  int nbytes = 0, nsent = 0, done_cnt = 0, cts_mode = 0;
  bit fixed_lat = 0;
  logic cts_at_edge = 1;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  img_to_uart #(.IMG_HEIGHT(H), .IMG_WIDTH(W)) dut (
    .clock(clk), .reset(rst), .img_send_start(start), .laptop_can_receive(cts),
    .pix_data(pix), .uart_data_sent(sent), .row_idx(row), .col_idx(col),
    .send_uart_data(send), .uart_data_tx(tx), .img_send_busy(busy), .img_send_done(done)
  );
  img_to_uart #(.IMG_HEIGHT(1), .IMG_WIDTH(1)) dut1 (
    .clock(clk), .reset(rst), .img_send_start(start1), .laptop_can_receive(1'b1),
    .pix_data(pix1), .uart_data_sent(sent1), .row_idx(row1), .col_idx(col1),
    .send_uart_data(send1), .uart_data_tx(tx1), .img_send_busy(busy1), .img_send_done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
`ifdef IMG_TX_HEADER_EN
    expq.push_back(8'hA5);
    expq.push_back(8'h5A);
    expq.push_back(8'(H));
    expq.push_back(8'(W));
`endif
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) expq.push_back(8'(r * 16 + c));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
  endtask

  task automatic post_checks(input int n0);
    @(negedge clk);
    check("done_once", done_cnt, 1);
    check("done_low", done, 0);
    check("busy_after", busy, 0);
    check("bytes_left", expq.size(), 0);
    check("byte_count", nbytes - n0, H * W + NHDR);
    check("row_home", row, 0);
    check("col_home", col, 0);
  endtask

  // frame store with one-cycle read latency: data reflects the address of the previous cycle
  initial begin
    logic [15:0] a;
    a = 0;
    forever begin
      @(posedge clk); #1;
      pix = 8'(a[15:8] * 16 + a[7:0]);
      a = {row, col};
    end
  end

  // uart_tcvr stand-in: pulses sent a few cycles after each new request
  initial begin
    int cnt;
    bit act;
    cnt = 0;
    act = 0;
    forever begin
      @(posedge clk); #1;
      sent = 0;
      if (rst) act = 0;
      else if (act) begin
        if (cnt == 0) begin sent = 1; act = 0; nsent++; end
        else cnt--;
      end else if (send) begin
        act = 1;
        cnt = fixed_lat ? 8 : $urandom_range(3, 12);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cts_at_edge = cts;
    #1;
    cts = cts_mode == 0 ? 1'b1 : cts_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic prev;
    logic [7:0] hold;
    prev = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst) prev = 0;
      else begin
        if (send && !prev) begin
          check("cts_before_byte", cts_at_edge, 1);
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h want none", tx);
          end else begin
            check("byte", tx, expq.pop_front());
            nbytes++;
          end
          hold = tx;
        end else if (send) check("tx_stable", tx, hold);
        if (done) done_cnt++;
        prev = send;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, s0;
    bit ok;
    logic [7:0] q1[$];
    repeat (2) @(negedge clk);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_send", send, 0);
    check("rst_tx", tx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst = 0;

    // fixed-latency frame, CTS high
    fixed_lat = 1;
    push_frame();
    done_cnt = 0;
    n0 = nbytes;
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!send && n < 20);
    check("start_to_send", n, LAT);
    check("busy_high", busy, 1);
    wait_done();
    post_checks(n0);

    // CTS held low after the 2nd byte, start pulses mid-frame and in DONE
    fixed_lat = 0;
    push_frame();
    done_cnt = 0;
    n0 = nbytes;
    s0 = nsent;
    pulse_start();
    n = 0;
    while (nsent < s0 + 2 && n < 500) begin @(negedge clk); n++; end
    cts_mode = 2;
    ok = 1;
    repeat (50) begin @(negedge clk); if (send) ok = 0; end
    check("cts_hold", ok, 1);
    cts_mode = 0;
    pulse_start();
    wait_done();
    start = 1;
    @(posedge clk); #1 start = 0;
    post_checks(n0);
    ok = 1;
    repeat (20) begin @(negedge clk); if (send || busy) ok = 0; end
    check("no_requeue", ok, 1);

    // random CTS, restart one cycle after DONE
    cts_mode = 1;
    push_frame();
    pulse_start();
    wait_done();
    push_frame();
    @(posedge clk); #1 start = 1;
    done_cnt = 0;
    n0 = nbytes;
    @(posedge clk); #1 start = 0;
    check("restart_busy", busy, 1);
    check("restart_origin", {row, col}, 0);
    wait_done();
    post_checks(n0);

    repeat (2) begin
      push_frame();
      done_cnt = 0;
      n0 = nbytes;
      pulse_start();
      wait_done();
      post_checks(n0);
    end

    // reset while the 4th byte is in flight
    cts_mode = 0;
    push_frame();
    n0 = nbytes;
    pulse_start();
    n = 0;
    while (nbytes < n0 + 4 && n < 500) begin @(negedge clk); n++; end
    check("in_send", send, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    expq.delete();
    check("mid_rst_row", row, 0);
    check("mid_rst_col", col, 0);
    check("mid_rst_send", send, 0);
    check("mid_rst_tx", tx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    ok = 1;
    repeat (5) begin @(negedge clk); if (send || busy) ok = 0; end
    check("mid_rst_idle", ok, 1);
    push_frame();
    done_cnt = 0;
    n0 = nbytes;
    pulse_start();
    wait_done();
    post_checks(n0);

    // 1x1 frame driven by hand
`ifdef IMG_TX_HEADER_EN
    q1.push_back(8'hA5);
    q1.push_back(8'h5A);
    q1.push_back(8'd1);
    q1.push_back(8'd1);
`endif
    q1.push_back(8'h3C);
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!send1 && n < 20);
    check("lat_1x1", n, LAT);
    for (int i = 0; i < q1.size(); i++) begin
      n = 0;
      while (!send1 && n < 20) begin @(negedge clk); n++; end
      check("send1_seen", send1, 1);
      check("byte_1x1", tx1, q1[i]);
      @(posedge clk); #1 sent1 = 1;
      @(posedge clk); #1 sent1 = 0;
      check("send1_drop", send1, 0);
      check("done_1x1", done1, i == q1.size() - 1);
    end
    @(posedge clk); #1;
    check("done1_once", done1, 0);
    check("busy1_after", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/img_to_uart.md
# img_to_uart

Streams a stored grayscale frame (e.g. the current downscaled pyramid level) back to the laptop over UART, one byte per pixel in raster order. It reads the frame through a row/column address port and drives `uart_tcvr` through the `send_uart_data` / `uart_data_sent` handshake. It honors laptop-side CTS flow control before each byte. It is the transmit counterpart of `uart_to_img` and is used for on-host inspection of FPGA image state.

## Interface
- `IMG_HEIGHT`, default 120: frame rows. Range 1–255.
- `IMG_WIDTH`, default 160: frame columns. Range 1–255.
- `clock` input 1: sole clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `img_send_start` input 1: single-cycle request to transmit the frame. Ignored unless idle.
- `laptop_can_receive` input 1: CTS from the laptop. High means a new byte may start.
- `pix_data` input 8: frame pixel at (`row_idx`, `col_idx`). Must be valid one cycle after the address changes.
- `uart_data_sent` input 1: single-cycle pulse from `uart_tcvr` when the current byte is finished.
- `row_idx` output 8: read row address.
- `col_idx` output 8: read column address.
- `send_uart_data` output 1: level request to `uart_tcvr`.
- `uart_data_tx` output 8: byte to transmit. Stable while `send_uart_data` is high.
- `img_send_busy` output 1: high from acceptance of start until DONE.
- `img_send_done` output 1: one-cycle pulse after the last byte is sent.

## Operation
- Reset values: `row_idx`=0, `col_idx`=0, `send_uart_data`=0, `uart_data_tx`=0, `img_send_busy`=0, `img_send_done`=0, state IDLE.
- States and transitions:
  - IDLE → HDR on `img_send_start` when the header is enabled, otherwise → FETCH.
  - HDR: emits the header bytes through the same CTS/SEND sequence, then → FETCH.
  - FETCH: address is held for one cycle, then → LOAD.
  - LOAD: `pix_data` is registered into `uart_data_tx`. Then → SEND if `laptop_can_receive`, else → WAIT_CTS.
  - WAIT_CTS: hold until `laptop_can_receive`=1, then → SEND.
  - SEND: `send_uart_data`=1 until `uart_data_sent`.
    - On that pulse, advance the raster counter.
    - If the last pixel was just sent → DONE, else → FETCH.
  - DONE: `img_send_done`=1 for one cycle → IDLE.
- Raster counter:
  - `col_idx` increments per byte and wraps to 0 after `IMG_WIDTH-1`.
  - `row_idx` increments on column wrap.
  - Both return to 0 after pixel (`IMG_HEIGHT-1`, `IMG_WIDTH-1`).
- Total payload is exactly `IMG_HEIGHT*IMG_WIDTH` bytes.
- `send_uart_data` drops in the cycle after `uart_data_sent`. There is at least one low cycle between bytes.
- CTS is sampled only before a byte starts. A low CTS during SEND does not abort the byte.
- `img_send_start` during busy or DONE is ignored. It is not queued.
- `uart_data_sent` outside SEND is ignored.
- `reset` asserted mid-frame returns every output to its reset value on that edge. No partial byte is re-requested.
- A 1×1 frame sends one byte, then goes to DONE.

## Timing
- Start to first `send_uart_data` with CTS high and header disabled: 3 cycles (IDLE→FETCH→LOAD→SEND).
- Per-pixel overhead beyond `uart_tcvr` time: 2 cycles (FETCH, LOAD).
- `uart_data_sent` pulse to `img_send_done`: 1 cycle after the last byte (SEND→DONE).
- `img_send_busy` rises on the edge that accepts start. It falls on the edge leaving DONE.

## Configuration
- `IMG_TX_HEADER_EN` defined:
  - Four header bytes precede the pixels: 0xA5, 0x5A, `IMG_HEIGHT`, `IMG_WIDTH`.
  - Each header byte obeys CTS and the handshake.
  - A 2-bit header counter selects the byte.
  - Total bytes = H*W+4.
- Macro undefined:
  - The HDR state and header counter are absent.
  - IDLE goes directly to FETCH.
  - Only pixel bytes are sent.

## Structure
- Package `img_tx_pkg` holds:
  - the state enum (IDLE, HDR, FETCH, LOAD, WAIT_CTS, SEND, DONE);
  - the header constants `IMG_TX_SYNC0`=8'hA5 and `IMG_TX_SYNC1`=8'h5A;
  - the header length 4.
- Sub-module `raster_counter`, parameterized by height and width.
  - Inputs: `advance`, `clear`.
  - Outputs: `row_idx`, `col_idx`, `last`.
  - It is reusable by the receive path.

## Test plan
- H=2, W=3, header off, CTS=1, pix_data=row*16+col, tcvr model returns sent 10 cycles after send → bytes 0x00,0x01,0x02,0x10,0x11,0x12 in order; done pulses once; busy low afterward.
- Header on, same frame → first bytes 0xA5,0x5A,0x02,0x03, then the 6 pixels; total 10 bytes.
- CTS held low for 50 cycles after the 2nd byte → `send_uart_data` stays low for those 50 cycles, resumes with 0x02, and no byte is lost or duplicated.
- `img_send_start` pulsed again mid-frame and in DONE → ignored; exactly one frame sent; a start one cycle after DONE begins a new frame at (0,0).
- `reset` asserted during 4th-byte SEND → next cycle all outputs are 0 and the state is IDLE; a following start resends from 0x00.
- H=1, W=1, header off → one byte, `img_send_done` exactly 1 cycle after `uart_data_sent`; start-to-send latency exactly 3 cycles.
